// File: rtl/detector_secuencia.sv
// -----------------------------------------------------------------------------
// detector_secuencia
//
// Mealy serial-pattern detector for a manually operated push-button.  The raw
// button is debounced on a slow clock enable, sampled once per step tick, and
// matched against PATRON (MSB entered first).  Mismatches fall back to the
// longest pattern prefix that is still a suffix of what was entered, so no
// partial match is lost.
//
// Build option:
//   DETECTOR_CUENTA_EN  defined   -> 8-bit saturating detection counter drives
//                                    cuenta
//                       undefined -> counter removed, cuenta tied to 8'd0
//
// Parameters:
//   N_BITS    pattern length (2..16)
//   PATRON    pattern, N_BITS wide, MSB is the first bit entered
//   DIV_DEB   divider bit whose rising edge gives the debounce tick
//   DIV_PASO  divider bit whose rising edge gives the step tick (> DIV_DEB)
//   SOLAPE    1 = overlapping detection, 0 = restart empty after a match
//
// Ports:
//   clk           in   system clock
//   rst           in   asynchronous active-high reset
//   boton         in   raw push-button level (asynchronous)
//   ledSecuencia  out  high for one step period after a detection
//   ledPasos      out  progress thermometer, MSB side fills first
//   cuenta        out  saturating detection count
//
// Match progress r_k:
//   r_k        | meaning
//   0          | nothing of the pattern matched
//   1..N_BITS-1| that many leading pattern bits matched
// -----------------------------------------------------------------------------
module detector_secuencia #(
    parameter int                N_BITS   = 4,
    parameter logic [N_BITS-1:0] PATRON   = 4'b1011,
    parameter int                DIV_DEB  = 19,
    parameter int                DIV_PASO = 24,
    parameter bit                SOLAPE   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              boton,
    output logic              ledSecuencia,
    output logic [N_BITS-1:0] ledPasos,
    output logic [7:0]        cuenta
);

    localparam int                KW     = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam int                TBL_N  = 2 * N_BITS;
    localparam int                TBL_W  = TBL_N * KW;
    localparam logic [KW-1:0]     K_LAST = KW'(N_BITS - 1);
    localparam logic [N_BITS-1:0] ONES   = '1;

    // Pattern in entry order: PAT_ORD[i] is the i-th bit the user enters.
    function automatic logic [N_BITS-1:0] order_pattern();
        logic [N_BITS-1:0] r;
        r = '0;
        for (int i = 0; i < N_BITS; i++) begin
            r[i] = PATRON[N_BITS-1-i];
        end
        return r;
    endfunction

    localparam logic [N_BITS-1:0] PAT_ORD = order_pattern();

    // Transition table, entry (2*k + b): longest proper pattern prefix that
    // is a suffix of (first k pattern bits, then b).  A plain match yields
    // k+1; the full-match entry yields the pattern's own border, which is
    // exactly the overlap restart point.
    function automatic logic [TBL_W-1:0] build_next_tbl();
        logic [TBL_W-1:0]  tbl;
        logic [N_BITS-1:0] s;
        logic              ok;
        int                best;
        tbl = '0;
        for (int k = 0; k < N_BITS; k++) begin
            for (int b = 0; b < 2; b++) begin
                s = '0;
                for (int i = 0; i < k; i++) begin
                    s[i] = PAT_ORD[i];
                end
                s[k] = b[0];
                best = 0;
                for (int len = 1; len < N_BITS; len++) begin
                    if (len <= k + 1) begin
                        ok = 1'b1;
                        for (int j = 0; j < len; j++) begin
                            if (s[k+1-len+j] != PAT_ORD[j]) begin
                                ok = 1'b0;
                            end
                        end
                        if (ok) begin
                            best = len;
                        end
                    end
                end
                tbl[(2*k+b)*KW +: KW] = best[KW-1:0];
            end
        end
        return tbl;
    endfunction

    localparam logic [TBL_W-1:0] NEXT_TBL = build_next_tbl();

    logic [DIV_PASO:0] r_clkdiv;
    logic              r_deb_prev;
    logic              r_paso_prev;
    logic              w_tick_deb;
    logic              w_tick_paso;

    logic              r_delay_1;
    logic              r_delay_2;
    logic              w_boton_deb;

    logic [KW-1:0]     r_k;
    logic [KW-1:0]     w_next_tbl [TBL_N];
    logic [KW:0]       w_tbl_idx;
    logic [KW-1:0]     w_k_fb;
    logic [KW-1:0]     w_k_new;
    logic              w_match;
    logic              w_detect;

    logic              r_led_sec;
    logic [N_BITS-1:0] r_led_pasos;

    // -------------------------------------------------------------------------
    // Divider and clock-enable ticks.  Comparing against the registered copy
    // of the bit means the 1->0 transition on wrap never produces a tick.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clkdiv    <= '0;
            r_deb_prev  <= 1'b0;
            r_paso_prev <= 1'b0;
        end else begin
            r_clkdiv    <= r_clkdiv + 1'b1;
            r_deb_prev  <= r_clkdiv[DIV_DEB];
            r_paso_prev <= r_clkdiv[DIV_PASO];
        end
    end

    assign w_tick_deb  = r_clkdiv[DIV_DEB]  & ~r_deb_prev;
    assign w_tick_paso = r_clkdiv[DIV_PASO] & ~r_paso_prev;

    // -------------------------------------------------------------------------
    // Debounce: the button is only sampled at the slow tick rate, which also
    // gives the first stage a full tick period to resolve metastability.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_delay_1 <= 1'b0;
            r_delay_2 <= 1'b0;
        end else if (w_tick_deb) begin
            r_delay_1 <= boton;
            r_delay_2 <= r_delay_1;
        end
    end

    assign w_boton_deb = r_delay_1 & r_delay_2;

    // -------------------------------------------------------------------------
    // Match progress
    // -------------------------------------------------------------------------
    for (genvar g = 0; g < TBL_N; g++) begin : g_tbl
        assign w_next_tbl[g] = NEXT_TBL[g*KW +: KW];
    end

    assign w_tbl_idx = {r_k, w_boton_deb};
    assign w_k_fb    = w_next_tbl[w_tbl_idx];
    assign w_match   = (w_boton_deb == PAT_ORD[r_k]);
    assign w_detect  = w_match && (r_k == K_LAST);
    assign w_k_new   = (w_detect && !SOLAPE) ? '0 : w_k_fb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k         <= '0;
            r_led_sec   <= 1'b0;
            r_led_pasos <= '0;
        end else if (w_tick_paso) begin
            r_k         <= w_k_new;
            r_led_sec   <= w_detect;
            // Thermometer: the top w_k_new bits are lit.
            r_led_pasos <= w_detect ? ONES : ~(ONES >> w_k_new);
        end
    end

    assign ledSecuencia = r_led_sec;
    assign ledPasos     = r_led_pasos;

    // -------------------------------------------------------------------------
    // Detection counter
    // -------------------------------------------------------------------------
`ifdef DETECTOR_CUENTA_EN
    logic [7:0] r_cuenta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cuenta <= 8'd0;
        end else if (w_tick_paso && w_detect && (r_cuenta != 8'hFF)) begin
            r_cuenta <= r_cuenta + 8'd1;
        end
    end

    assign cuenta = r_cuenta;
`else
    assign cuenta = 8'd0;
`endif

endmodule

// File: tb/tb_detector_secuencia.sv
module tb_detector_secuencia;

    localparam int         N        = 4;
    localparam logic [3:0] PAT      = 4'b1011;
    localparam int         STEP_CLK = 16;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       boton = 1'b0;

    logic       led_ov,   led_no;
    logic [3:0] pasos_ov, pasos_no;
    logic [7:0] cnt_ov,   cnt_no;

    always #5 clk = ~clk;

    detector_secuencia #(
        .N_BITS(4), .PATRON(4'b1011), .DIV_DEB(1), .DIV_PASO(3), .SOLAPE(1'b1)
    ) dut_ov (
        .clk(clk), .rst(rst), .boton(boton),
        .ledSecuencia(led_ov), .ledPasos(pasos_ov), .cuenta(cnt_ov)
    );

    detector_secuencia #(
        .N_BITS(4), .PATRON(4'b1011), .DIV_DEB(1), .DIV_PASO(3), .SOLAPE(1'b0)
    ) dut_no (
        .clk(clk), .rst(rst), .boton(boton),
        .ledSecuencia(led_no), .ledPasos(pasos_no), .cuenta(cnt_no)
    );

    int errors = 0;
    int checks = 0;
    bit cnt_en;

    // Reference model: history of sampled bits since reset (or since the last
    // non-overlapping match), judged directly against the pattern.
    bit         hist_ov[$];
    bit         hist_no[$];
    logic       e_led_ov, e_led_no;
    logic [3:0] e_pasos_ov, e_pasos_no;
    int         e_cnt_ov, e_cnt_no;

    function automatic bit is_hit(input bit h[$]);
        logic [3:0] p;
        int         n;
        p = PAT;
        n = h.size();
        if (n < N) return 1'b0;
        for (int j = 0; j < N; j++) begin
            if (h[n-N+j] != p[N-1-j]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int border_len(input bit h[$]);
        logic [3:0] p;
        int         best;
        int         n;
        bit         ok;
        p    = PAT;
        best = 0;
        n    = h.size();
        for (int len = 1; len < N; len++) begin
            if (len <= n) begin
                ok = 1'b1;
                for (int j = 0; j < len; j++) begin
                    if (h[n-len+j] != p[N-1-j]) ok = 1'b0;
                end
                if (ok) best = len;
            end
        end
        return best;
    endfunction

    function automatic logic [3:0] thermo(input int k);
        logic [3:0] t;
        t = 4'b0000;
        for (int i = 0; i < N; i++) begin
            if (i < k) t[N-1-i] = 1'b1;
        end
        return t;
    endfunction

    task automatic model_reset();
        hist_ov.delete();
        hist_no.delete();
        e_led_ov = 1'b0; e_pasos_ov = 4'b0000; e_cnt_ov = 0;
        e_led_no = 1'b0; e_pasos_no = 4'b0000; e_cnt_no = 0;
    endtask

    task automatic model_update(input bit b);
        bit hit;
        hist_ov.push_back(b);
        hit = is_hit(hist_ov);
        e_led_ov = hit;
        if (hit && cnt_en && e_cnt_ov < 255) e_cnt_ov++;
        e_pasos_ov = hit ? 4'b1111 : thermo(border_len(hist_ov));
        while (hist_ov.size() > N) void'(hist_ov.pop_front());

        hist_no.push_back(b);
        hit = is_hit(hist_no);
        e_led_no = hit;
        if (hit && cnt_en && e_cnt_no < 255) e_cnt_no++;
        if (hit) hist_no.delete();
        e_pasos_no = hit ? 4'b1111 : thermo(border_len(hist_no));
        while (hist_no.size() > N) void'(hist_no.pop_front());
    endtask

    // Releases reset with boton already at first_bit; the first step tick
    // (divider reaching 8) is applied on the 9th rising edge.
    task automatic reset_release(input bit first_bit);
        boton = first_bit;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (9) @(posedge clk);
        #1;
        model_update(first_bit);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic drive_step(input bit b);
        boton = b;
        repeat (STEP_CLK) @(posedge clk);
        #1;
        model_update(b);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (led_ov !== 1'b0) begin errors++; $display("FAIL reset_led_ov: got %b expected 0", led_ov); end
        checks++; if (pasos_ov !== 4'b0000) begin errors++; $display("FAIL reset_pasos_ov: got %b expected 0000", pasos_ov); end
        checks++; if (cnt_ov !== 8'd0) begin errors++; $display("FAIL reset_cnt_ov: got %0d expected 0", cnt_ov); end
        checks++; if (led_no !== 1'b0) begin errors++; $display("FAIL reset_led_no: got %b expected 0", led_no); end
        checks++; if (pasos_no !== 4'b0000) begin errors++; $display("FAIL reset_pasos_no: got %b expected 0000", pasos_no); end
        checks++; if (cnt_no !== 8'd0) begin errors++; $display("FAIL reset_cnt_no: got %0d expected 0", cnt_no); end
        reset_release(1'b0);
        checks++; if (pasos_ov !== 4'b0000) begin errors++; $display("FAIL reset_step0_pasos_ov: got %b expected 0000", pasos_ov); end
        checks++; if (led_ov !== 1'b0) begin errors++; $display("FAIL reset_step0_led_ov: got %b expected 0", led_ov); end
    endtask

    // A 2-clk pulse between debounce samples must not reach the detector.
    task automatic test_glitch();
        boton = 1'b0;
        repeat (2) @(posedge clk);
        #1 boton = 1'b1;
        repeat (2) @(posedge clk);
        #1 boton = 1'b0;
        repeat (STEP_CLK - 4) @(posedge clk);
        #1;
        model_update(1'b0);
        checks++; if (pasos_ov !== 4'b0000) begin errors++; $display("FAIL glitch_pasos_ov: got %b expected 0000", pasos_ov); end
        checks++; if (pasos_no !== 4'b0000) begin errors++; $display("FAIL glitch_pasos_no: got %b expected 0000", pasos_no); end
        checks++; if (led_ov !== 1'b0) begin errors++; $display("FAIL glitch_led_ov: got %b expected 0", led_ov); end
    endtask

    task automatic test_basic();
        logic [3:0]  bits;
        logic [15:0] exp_p;
        bits  = 4'b1011;
        exp_p = 16'h8CEF;
        for (int s = 0; s < 4; s++) begin
            drive_step(bits[3-s]);
            checks++;
            if (pasos_ov !== exp_p[15-4*s -: 4]) begin
                errors++; $display("FAIL basic_pasos_ov step %0d: got %b expected %b", s + 1, pasos_ov, exp_p[15-4*s -: 4]);
            end
            checks++;
            if (led_ov !== (s == 3)) begin
                errors++; $display("FAIL basic_led_ov step %0d: got %b expected %b", s + 1, led_ov, (s == 3));
            end
        end
        checks++; if (cnt_ov !== (cnt_en ? 8'd1 : 8'd0)) begin errors++; $display("FAIL basic_cnt_ov: got %0d expected %0d", cnt_ov, cnt_en ? 1 : 0); end
        // Flag holds for the whole step period, then clears.
        boton = 1'b0;
        repeat (STEP_CLK / 2) @(posedge clk);
        #1;
        checks++; if (led_ov !== 1'b1) begin errors++; $display("FAIL basic_led_hold: got %b expected 1", led_ov); end
        repeat (STEP_CLK / 2) @(posedge clk);
        #1;
        model_update(1'b0);
        checks++; if (led_ov !== 1'b0) begin errors++; $display("FAIL basic_led_clear: got %b expected 0", led_ov); end
        checks++; if (pasos_ov !== e_pasos_ov) begin errors++; $display("FAIL basic_after_pasos_ov: got %b expected %b", pasos_ov, e_pasos_ov); end
    endtask

    task automatic test_overlap();
        logic [6:0] bits;
        logic [6:0] exp_ov;
        logic [6:0] exp_no;
        bits   = 7'b1011011;
        exp_ov = 7'b0001001;
        exp_no = 7'b0001000;
        apply_reset();
        reset_release(bits[6]);
        for (int s = 0; s < 7; s++) begin
            if (s > 0) drive_step(bits[6-s]);
            checks++;
            if (led_ov !== exp_ov[6-s]) begin errors++; $display("FAIL overlap_led_ov step %0d: got %b expected %b", s + 1, led_ov, exp_ov[6-s]); end
            checks++;
            if (led_no !== exp_no[6-s]) begin errors++; $display("FAIL overlap_led_no step %0d: got %b expected %b", s + 1, led_no, exp_no[6-s]); end
        end
        checks++; if (cnt_ov !== (cnt_en ? 8'd2 : 8'd0)) begin errors++; $display("FAIL overlap_cnt_ov: got %0d expected %0d", cnt_ov, cnt_en ? 2 : 0); end
        checks++; if (cnt_no !== (cnt_en ? 8'd1 : 8'd0)) begin errors++; $display("FAIL overlap_cnt_no: got %0d expected %0d", cnt_no, cnt_en ? 1 : 0); end
        checks++; if (pasos_no !== 4'b1000) begin errors++; $display("FAIL overlap_pasos_no: got %b expected 1000", pasos_no); end
    endtask

    task automatic test_fallback();
        logic [5:0] bits;
        bits = 6'b101011;
        apply_reset();
        reset_release(bits[5]);
        for (int s = 1; s < 6; s++) begin
            drive_step(bits[5-s]);
            if (s == 3) begin
                checks++; if (pasos_ov !== 4'b1100) begin errors++; $display("FAIL fallback_pasos_ov: got %b expected 1100", pasos_ov); end
                checks++; if (pasos_no !== 4'b1100) begin errors++; $display("FAIL fallback_pasos_no: got %b expected 1100", pasos_no); end
            end
            if (s == 4) begin
                checks++; if (led_ov !== 1'b0) begin errors++; $display("FAIL fallback_early_led: got %b expected 0", led_ov); end
            end
        end
        checks++; if (led_ov !== 1'b1) begin errors++; $display("FAIL fallback_led_ov: got %b expected 1", led_ov); end
        checks++; if (led_no !== 1'b1) begin errors++; $display("FAIL fallback_led_no: got %b expected 1", led_no); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        reset_release(1'b1);
        drive_step(1'b0);
        drive_step(1'b1);
        checks++; if (pasos_ov !== 4'b1110) begin errors++; $display("FAIL rstmid_pre_pasos: got %b expected 1110", pasos_ov); end
        boton = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++; if (pasos_ov !== 4'b0000) begin errors++; $display("FAIL rstmid_pasos_ov: got %b expected 0000", pasos_ov); end
        checks++; if (pasos_no !== 4'b0000) begin errors++; $display("FAIL rstmid_pasos_no: got %b expected 0000", pasos_no); end
        checks++; if (led_ov !== 1'b0 || led_no !== 1'b0) begin errors++; $display("FAIL rstmid_led: got %b%b expected 00", led_ov, led_no); end
        checks++; if (cnt_ov !== 8'd0 || cnt_no !== 8'd0) begin errors++; $display("FAIL rstmid_cnt: got %0d,%0d expected 0,0", cnt_ov, cnt_no); end
        reset_release(1'b1);
        drive_step(1'b0);
        drive_step(1'b1);
        checks++; if (led_ov !== 1'b0) begin errors++; $display("FAIL rstmid_step3_led: got %b expected 0", led_ov); end
        drive_step(1'b1);
        checks++; if (led_ov !== 1'b1) begin errors++; $display("FAIL rstmid_step4_led_ov: got %b expected 1", led_ov); end
        checks++; if (led_no !== 1'b1) begin errors++; $display("FAIL rstmid_step4_led_no: got %b expected 1", led_no); end
    endtask

    task automatic test_random();
        bit b;
        apply_reset();
        reset_release(1'b0);
        for (int s = 0; s < 150; s++) begin
            b = 1'($urandom_range(0, 1));
            drive_step(b);
            checks++; if (led_ov !== e_led_ov) begin errors++; $display("FAIL rand_led_ov step %0d: got %b expected %b", s, led_ov, e_led_ov); end
            checks++; if (pasos_ov !== e_pasos_ov) begin errors++; $display("FAIL rand_pasos_ov step %0d: got %b expected %b", s, pasos_ov, e_pasos_ov); end
            checks++; if (cnt_ov !== 8'(e_cnt_ov)) begin errors++; $display("FAIL rand_cnt_ov step %0d: got %0d expected %0d", s, cnt_ov, e_cnt_ov); end
            checks++; if (led_no !== e_led_no) begin errors++; $display("FAIL rand_led_no step %0d: got %b expected %b", s, led_no, e_led_no); end
            checks++; if (pasos_no !== e_pasos_no) begin errors++; $display("FAIL rand_pasos_no step %0d: got %b expected %b", s, pasos_no, e_pasos_no); end
            checks++; if (cnt_no !== 8'(e_cnt_no)) begin errors++; $display("FAIL rand_cnt_no step %0d: got %0d expected %0d", s, cnt_no, e_cnt_no); end
        end
    endtask

    // 1011 followed by repeated 011 gives one overlapping match per group.
    task automatic test_saturation();
        logic [3:0] head;
        logic [2:0] tail;
        int         nb;
        int         pulses;
        bit         b;
        head   = 4'b1011;
        tail   = 3'b011;
        pulses = 0;
        apply_reset();
        reset_release(1'b0);
        for (int r = 0; r < 261; r++) begin
            nb = (r == 0) ? 4 : 3;
            for (int j = 0; j < nb; j++) begin
                b = (r == 0) ? head[3-j] : tail[2-j];
                drive_step(b);
                if (led_ov === 1'b1) pulses++;
                checks++; if (led_ov !== e_led_ov) begin errors++; $display("FAIL sat_led_ov grp %0d: got %b expected %b", r, led_ov, e_led_ov); end
                checks++; if (cnt_ov !== 8'(e_cnt_ov)) begin errors++; $display("FAIL sat_cnt_ov grp %0d: got %0d expected %0d", r, cnt_ov, e_cnt_ov); end
                checks++; if (cnt_no !== 8'(e_cnt_no)) begin errors++; $display("FAIL sat_cnt_no grp %0d: got %0d expected %0d", r, cnt_no, e_cnt_no); end
            end
            if (r == 259) begin
                checks++; if (pulses != 260) begin errors++; $display("FAIL sat_pulses: got %0d expected 260", pulses); end
                checks++; if (cnt_ov !== (cnt_en ? 8'd255 : 8'd0)) begin errors++; $display("FAIL sat_cnt_260: got %0d expected %0d", cnt_ov, cnt_en ? 255 : 0); end
            end
        end
        checks++; if (pulses != 261) begin errors++; $display("FAIL sat_pulses_final: got %0d expected 261", pulses); end
        checks++; if (cnt_ov !== (cnt_en ? 8'd255 : 8'd0)) begin errors++; $display("FAIL sat_cnt_hold: got %0d expected %0d", cnt_ov, cnt_en ? 255 : 0); end
    endtask

    initial begin
`ifdef DETECTOR_CUENTA_EN
        cnt_en = 1'b1;
`else
        cnt_en = 1'b0;
`endif
        model_reset();
        test_reset();
        test_glitch();
        test_basic();
        test_overlap();
        test_fallback();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
